// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline stall/flush sequencer.
// The stage-control bundle groups every per-cycle pipeline control into one value.
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
        logic memwb_bubble;
        logic dmem_req;
    } stage_ctrl_t;

    // Normal forward progress: fetch and decode advance, nothing squashed.
    localparam stage_ctrl_t CTRL_RUN = '{
        pc_write:     1'b1,
        ifid_write:   1'b1,
        ifid_flush:   1'b0,
        idex_bubble:  1'b0,
        pipe_hold:    1'b0,
        memwb_bubble: 1'b0,
        dmem_req:     1'b0
    };

    // Whole pipeline squashed while reset is asserted.
    localparam stage_ctrl_t CTRL_RESET = '{
        pc_write:     1'b0,
        ifid_write:   1'b0,
        ifid_flush:   1'b1,
        idex_bubble:  1'b1,
        pipe_hold:    1'b0,
        memwb_bubble: 1'b1,
        dmem_req:     1'b0
    };

    // Front end frozen, ID/EX and EX/MEM held, write-back fed a bubble.
    localparam stage_ctrl_t CTRL_MEM_HOLD = '{
        pc_write:     1'b0,
        ifid_write:   1'b0,
        ifid_flush:   1'b0,
        idex_bubble:  1'b0,
        pipe_hold:    1'b1,
        memwb_bubble: 1'b1,
        dmem_req:     1'b1
    };

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// a source of the instruction in ID. Writes to $zero never create a hazard.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       idex_memread_i,
    input  logic [4:0] idex_rt_addr_i,
    input  logic [4:0] ifid_rs_addr_i,
    input  logic [4:0] ifid_rt_addr_i,
    input  logic       ifid_uses_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (idex_rt_addr_i == ifid_rs_addr_i);
    assign rt_match = ifid_uses_rt_i && (idex_rt_addr_i == ifid_rt_addr_i);

    assign load_use_o = idex_memread_i && (idex_rt_addr_i != REG_ZERO)
                        && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// taken-branch IF flush and multi-cycle data-memory waits with timeout.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RtAddr_i,
    input  logic [4:0]       IFID_RsAddr_i,
    input  logic [4:0]       IFID_RtAddr_i,
    input  logic             IFID_UsesRt_i,
    input  logic             Branch_taken_i,
    input  logic             EXMEM_MemAccess_i,
    input  logic             dmem_ack_i,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             pipe_hold_o,
    output logic             MEMWB_bubble_o,
    output logic             dmem_req_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int              WCNT_W  = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_TO = WCNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    ctrl_state_t       state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    stage_ctrl_t       ctrl;
    logic              lu;
    logic              mw;

    load_use_detect u_load_use_detect (
        .idex_memread_i (IDEX_MemRead_i),
        .idex_rt_addr_i (IDEX_RtAddr_i),
        .ifid_rs_addr_i (IFID_RsAddr_i),
        .ifid_rt_addr_i (IFID_RtAddr_i),
        .ifid_uses_rt_i (IFID_UsesRt_i),
        .load_use_o     (lu)
    );

    assign mw = EXMEM_MemAccess_i && !dmem_ack_i;

    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        if (!rst_i) begin
            ctrl = CTRL_RESET;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mw) begin
                        ctrl    = CTRL_MEM_HOLD;
                        state_d = MEM_WAIT;
                        wcnt_d  = WCNT_W'(1);
                    end else begin
                        // A zero-wait access still presents the request for its one cycle.
                        ctrl.dmem_req = EXMEM_MemAccess_i;
                        if (lu) begin
                            // Branch operands are not valid yet; it re-resolves next cycle.
                            ctrl.pc_write    = 1'b0;
                            ctrl.ifid_write  = 1'b0;
                            ctrl.idex_bubble = 1'b1;
                        end else if (Branch_taken_i) begin
                            ctrl.ifid_flush = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        ctrl.dmem_req = 1'b1;
                        state_d       = RUN;
                        wcnt_d        = '0;
                    end else if (wcnt_q == WCNT_TO) begin
                        // Drop the access: release the hold but squash write-back.
                        ctrl           = CTRL_MEM_HOLD;
                        ctrl.pipe_hold = 1'b0;
                        ctrl.dmem_req  = 1'b0;
                        err_d          = 1'b1;
                        state_d        = RUN;
                        wcnt_d         = '0;
                    end else begin
                        ctrl   = CTRL_MEM_HOLD;
                        wcnt_d = wcnt_q + WCNT_W'(1);
                    end
                end
                default: begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC_write_o     = ctrl.pc_write;
    assign IFID_write_o   = ctrl.ifid_write;
    assign IFID_flush_o   = ctrl.ifid_flush;
    assign IDEX_bubble_o  = ctrl.idex_bubble;
    assign pipe_hold_o    = ctrl.pipe_hold;
    assign MEMWB_bubble_o = ctrl.memwb_bubble;
    assign dmem_req_o     = ctrl.dmem_req;
    assign err_o          = err_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule
